fetch_sequencer: RTL

Instruction fetch/execute sequencer for the 16-bit core.
- Fetches one or two instruction words from instruction memory over a req/ack handshake.
- Loads the IR1/IR2 registers that feed instruction_decoder.
- Launches execution and waits for completion.
- Applies branch targets and handles halt.
- Traps on decode errors and on memory acknowledge timeouts.

---
 rtl/fetch_sequencer_pkg.sv | 27 ++
 rtl/fetch_ack_timer.sv | 40 ++++
 rtl/fetch_sequencer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared core types for the fetch/execute sequencer: state and trap encodings
// plus the program-counter width.
package fetch_sequencer_pkg;

    localparam int PC_W = 16;

    typedef enum logic [2:0] {
        FS_IDLE   = 3'd0,
        FS_FETCH1 = 3'd1,
        FS_CHECK  = 3'd2,
        FS_FETCH2 = 3'd3,
        FS_EXEC   = 3'd4,
        FS_HALT   = 3'd5,
        FS_TRAP   = 3'd6
    } fetch_state_e;

    typedef enum logic [1:0] {
        FE_NONE        = 2'd0,
        FE_DECODE      = 2'd1,
        FE_BUS_TIMEOUT = 2'd2
    } fetch_err_e;

    function automatic logic is_fetch_state(input fetch_state_e s);
        return (s == FS_FETCH1) || (s == FS_FETCH2);
    endfunction

endpackage

// File: rtl/fetch_ack_timer.sv
// Counts request cycles without an acknowledge; o_expire flags the last
// cycle in which an ack can still arrive before a bus-timeout trap.
module fetch_ack_timer #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam logic [7:0] LAST_CNT = 8'(ACK_TIMEOUT - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Saturates at LAST_CNT so a stalled owner cannot wrap back to a safe count.
    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_en && (cnt_q != LAST_CNT)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // NOTE: state registers use <= so every flop samples pre-edge values;
    // blocking = here would let one flop see another's new value in the same edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_expire = (cnt_q == LAST_CNT);

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch/execute sequencer: fetches one or two words into IR1/IR2,
// launches execution, applies branches, and traps on decode or bus errors.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC    = 16'h0000,
    parameter int              ACK_TIMEOUT = 16
) (
    input  logic            i_clk,
    input  logic            i_rst,
    output logic            o_mem_req,
    output logic [PC_W-1:0] o_mem_addr,
    input  logic            i_mem_ack,
    input  logic [15:0]     i_mem_rdata,
    output logic [15:0]     o_ir1,
    output logic [15:0]     o_ir2,
    input  logic            i_ext_word,
    input  logic            i_dec_err,
    output logic            o_ir_valid,
    output logic            o_exec_start,
    input  logic            i_exec_done,
    input  logic            i_pc_load,
    input  logic [PC_W-1:0] i_pc_target,
    input  logic            i_halt,
    output logic [PC_W-1:0] o_pc,
    output logic [2:0]      o_state,
    output logic            o_err,
    output logic [1:0]      o_err_code
);

    fetch_state_e    state_q, state_d;
    fetch_err_e      err_code_q, err_code_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     ir1_q, ir1_d;
    logic [15:0]     ir2_q, ir2_d;
    logic            exec_first_q;
    logic            ir_valid_q;
    logic            err_q;
    logic            fetching;
    logic            ack_expire;

    assign fetching = is_fetch_state(state_q);

    fetch_ack_timer #(
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_ack_timer (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clr    (!fetching || i_mem_ack),
        .i_en     (fetching && !i_mem_ack),
        .o_expire (ack_expire)
    );

    // NOTE: every variable gets its hold value first so no branch can leave
    // one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        err_code_d = err_code_q;
        pc_d       = pc_q;
        ir1_d      = ir1_q;
        ir2_d      = ir2_q;

        unique case (state_q)
            FS_IDLE: begin
                state_d = i_halt ? FS_HALT : FS_FETCH1;
            end
            FS_FETCH1, FS_FETCH2: begin
                // An ack in the expiry cycle still wins over the timeout.
                if (i_mem_ack) begin
                    pc_d = pc_q + 16'd1;
                    if (state_q == FS_FETCH1) begin
                        ir1_d   = i_mem_rdata;
                        ir2_d   = '0;
                        state_d = FS_CHECK;
                    end else begin
                        ir2_d   = i_mem_rdata;
                        state_d = FS_EXEC;
                    end
                end else if (ack_expire) begin
                    state_d    = FS_TRAP;
                    err_code_d = FE_BUS_TIMEOUT;
                end
            end
            FS_CHECK: begin
                if (i_dec_err) begin
                    state_d    = FS_TRAP;
                    err_code_d = FE_DECODE;
                end else if (i_ext_word) begin
                    state_d = FS_FETCH2;
                end else begin
                    state_d = FS_EXEC;
                end
            end
            FS_EXEC: begin
                if (i_dec_err) begin
                    state_d    = FS_TRAP;
                    err_code_d = FE_DECODE;
                end else if (i_exec_done) begin
                    pc_d    = i_pc_load ? i_pc_target : pc_q;
                    state_d = i_halt ? FS_HALT : FS_FETCH1;
                end
            end
            FS_HALT: begin
                if (!i_halt) begin
                    state_d = FS_FETCH1;
                end
            end
            FS_TRAP: begin
                state_d = FS_TRAP;
            end
            default: begin
                state_d = FS_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= FS_IDLE;
            err_code_q   <= FE_NONE;
            pc_q         <= RESET_PC;
            ir1_q        <= '0;
            ir2_q        <= '0;
            exec_first_q <= 1'b0;
            ir_valid_q   <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            err_code_q   <= err_code_d;
            pc_q         <= pc_d;
            ir1_q        <= ir1_d;
            ir2_q        <= ir2_d;
            exec_first_q <= (state_d == FS_EXEC) && (state_q != FS_EXEC);
            ir_valid_q   <= (state_d == FS_EXEC);
            err_q        <= (state_d == FS_TRAP);
        end
    end

    assign o_mem_req    = fetching;
    assign o_mem_addr   = pc_q;
    assign o_exec_start = (state_q == FS_EXEC) && exec_first_q;
    assign o_ir1        = ir1_q;
    assign o_ir2        = ir2_q;
    assign o_ir_valid   = ir_valid_q;
    assign o_pc         = pc_q;
    assign o_state      = state_q;
    assign o_err        = err_q;
    assign o_err_code   = err_code_q;

endmodule
